// File: rtl/keypad_debouncer_rpt.sv
// keypad_debouncer_rpt: debounces a keypad scanner's key code and key-down flag.
// It emits one-cycle press, release and optional auto-repeat strobes.
//
// Ports:
//   clk            scanner clock
//   reset          synchronous, active-low reset
//   sig_in         raw key code from the scanner
//   key_pressed    raw "a key is down" indication
//   sig_out        last accepted key code (all ones after reset)
//   press_pulse    one-cycle strobe when a press is accepted
//   release_pulse  one-cycle strobe when a release is accepted
//   repeat_pulse   one-cycle auto-repeat strobe (constant 0 when REPEAT_EN = 0)
//   held           high while a key is accepted as down (HELD or DEB_RELEASE)
module keypad_debouncer_rpt #(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned PRESS_CYCLES   = 1200,
  parameter int unsigned RELEASE_CYCLES = 1200,
  parameter int unsigned REPEAT_EN      = 0,
  parameter int unsigned REPEAT_DELAY   = 24000,
  parameter int unsigned REPEAT_PERIOD  = 4800
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sig_in,
  input  logic             key_pressed,
  output logic [WIDTH-1:0] sig_out,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             repeat_pulse,
  output logic             held
);

  localparam int unsigned DebMax = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES
                                                                   : RELEASE_CYCLES;
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                  : REPEAT_PERIOD;
  localparam int unsigned CntW   = $clog2(DebMax + 1);
  localparam int unsigned RcntW  = $clog2(RepMax + 1);

  localparam logic [CntW-1:0]  PressLast   = CntW'(PRESS_CYCLES - 1);
  localparam logic [CntW-1:0]  ReleaseLast = CntW'(RELEASE_CYCLES - 1);
  localparam logic [RcntW-1:0] DelayLast   = RcntW'(REPEAT_DELAY - 1);
  localparam logic [RcntW-1:0] PeriodLast  = RcntW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    StIdle       = 2'd0,
    StDebPress   = 2'd1,
    StHeld       = 2'd2,
    StDebRelease = 2'd3
  } state_e;

  state_e           state;
  logic [CntW-1:0]  cnt;
  logic [RcntW-1:0] rcnt;
  // Set after the first repeat: later repeats use the shorter period.
  logic             rep_period;
  logic [WIDTH-1:0] candidate;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= StIdle;
      cnt           <= '0;
      rcnt          <= '0;
      rep_period    <= 1'b0;
      candidate     <= '1;
      sig_out       <= '1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        StIdle: begin
          held <= 1'b0;
          if (key_pressed) begin
            state     <= StDebPress;
            candidate <= sig_in;
            cnt       <= '0;
          end
        end
        StDebPress: begin
          // Abort has priority over reaching the terminal count.
          if (!key_pressed) begin
            state <= StIdle;
          end else if (sig_in != candidate) begin
            candidate <= sig_in;
            cnt       <= '0;
          end else if (cnt == PressLast) begin
            state       <= StHeld;
            sig_out     <= candidate;
            press_pulse <= 1'b1;
            held        <= 1'b1;
            rcnt        <= '0;
            rep_period  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StHeld: begin
          if (!key_pressed) begin
            state <= StDebRelease;
            cnt   <= '0;
          end else if (REPEAT_EN != 0) begin
            if (rcnt == (rep_period ? PeriodLast : DelayLast)) begin
              repeat_pulse <= 1'b1;
              rcnt         <= '0;
              rep_period   <= 1'b1;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
        end
        StDebRelease: begin
          // A bounce back to pressed wins over the terminal count; rcnt is kept.
          if (key_pressed) begin
            state <= StHeld;
          end else if (cnt == ReleaseLast) begin
            state         <= StIdle;
            release_pulse <= 1'b1;
            held          <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= StIdle;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_debouncer_rpt.sv
module tb_keypad_debouncer_rpt;

  localparam logic [2:0] KPress   = 3'b100;
  localparam logic [2:0] KRelease = 3'b010;
  localparam logic [2:0] KRepeat  = 3'b001;

  typedef struct {
    logic [2:0] kind;
    logic [3:0] code;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sig_in = 4'h0;
  logic       key_pressed = 1'b0;
  logic [3:0] sig_out;
  logic       press_pulse, release_pulse, repeat_pulse, held;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  ev_t exp_q[$];

  keypad_debouncer_rpt #(
    .WIDTH(4), .PRESS_CYCLES(5), .RELEASE_CYCLES(4), .REPEAT_EN(1),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .reset(reset), .sig_in(sig_in), .key_pressed(key_pressed),
    .sig_out(sig_out), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse), .held(held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Inputs set now are first sampled at the next edge (cyc+1); the event
  // becomes visible after the edge lat cycles later.
  task automatic expect_ev(input logic [2:0] kind, input logic [3:0] code, input int at);
    ev_t e;
    e.kind = kind;
    e.code = code;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe seen must match the head of the expected queue.
  always @(negedge clk) begin
    ev_t        e;
    logic [2:0] k;
    k = {press_pulse, release_pulse, repeat_pulse};
    if (k != 3'b000) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got kind %b code 0x%0h, expected none (cycle %0d)",
                 k, sig_out, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", int'(k), int'(e.kind));
        chk("pulse_code", int'(sig_out), int'(e.code));
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    // Reset state
    tick(2);
    reset = 1'b1;
    chk("rst_sig_out", sig_out, 4'hF);
    chk("rst_held", held, 0);
    chk("rst_pulses", {press_pulse, release_pulse, repeat_pulse}, 0);

    // Press 7, then reset while held
    key_pressed = 1'b1; sig_in = 4'h7;
    expect_ev(KPress, 4'h7, cyc + 1 + 5);
    tick(6);
    chk("hold7_sig_out", sig_out, 4'h7);
    chk("hold7_held", held, 1);
    reset = 1'b0; key_pressed = 1'b0;
    tick(1);
    reset = 1'b1;
    chk("midhold_rst_sig_out", sig_out, 4'hF);
    chk("midhold_rst_held", held, 0);

    // Short press aborts
    key_pressed = 1'b1; sig_in = 4'h3;
    tick(3);
    key_pressed = 1'b0;
    tick(3);
    chk("abort_sig_out", sig_out, 4'hF);
    chk("abort_held", held, 0);

    // Clean press and release of 3
    key_pressed = 1'b1; sig_in = 4'h3;
    expect_ev(KPress, 4'h3, cyc + 1 + 5);
    tick(6);
    chk("press3_sig_out", sig_out, 4'h3);
    chk("press3_held", held, 1);
    key_pressed = 1'b0;
    expect_ev(KRelease, 4'h3, cyc + 1 + 4);
    tick(6);
    chk("rel3_held", held, 0);
    chk("rel3_sig_out", sig_out, 4'h3);

    // Code change restarts the window; then hold with repeats
    key_pressed = 1'b1; sig_in = 4'h3;
    tick(3);
    sig_in = 4'h6;
    expect_ev(KPress, 4'h6, cyc + 1 + 5);
    tick(6);
    chk("restart_sig_out", sig_out, 4'h6);
    expect_ev(KRepeat, 4'h6, cyc + 10);
    expect_ev(KRepeat, 4'h6, cyc + 13);
    expect_ev(KRepeat, 4'h6, cyc + 16);
    expect_ev(KRepeat, 4'h6, cyc + 19);
    tick(5);
    sig_in = 4'h1;
    tick(15);
    chk("hold_ignores_sig_in", sig_out, 4'h6);
    chk("hold_held", held, 1);

    // Release with one bounce
    key_pressed = 1'b0;
    tick(2);
    key_pressed = 1'b1;
    tick(1);
    key_pressed = 1'b0;
    expect_ev(KRelease, 4'h6, cyc + 1 + 4);
    tick(7);
    chk("bounce_rel_held", held, 0);
    chk("bounce_rel_sig_out", sig_out, 4'h6);

    // Key drops on the same edge the press count would complete: abort wins
    key_pressed = 1'b1; sig_in = 4'h5;
    tick(5);
    key_pressed = 1'b0;
    tick(3);
    chk("edge_abort_sig_out", sig_out, 4'h6);
    chk("edge_abort_held", held, 0);

    // Key rises on the same edge the release count would complete: HELD wins
    key_pressed = 1'b1; sig_in = 4'h9;
    expect_ev(KPress, 4'h9, cyc + 1 + 5);
    tick(6);
    key_pressed = 1'b0;
    tick(4);
    key_pressed = 1'b1;
    tick(1);
    chk("edge_bounce_held", held, 1);
    key_pressed = 1'b0;
    expect_ev(KRelease, 4'h9, cyc + 1 + 4);
    tick(7);
    chk("edge_bounce_rel_held", held, 0);
    chk("edge_bounce_sig_out", sig_out, 4'h9);

    tick(5);
    chk("missing_pulses", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_debouncer_rpt.md
Name: keypad_debouncer_rpt

Overview:
- Parametrised successor to the single-channel keypad debouncer.
- Debounces a WIDTH-bit key code qualified by key_pressed, with separate press and release debounce times.
- Restarts the debounce window if the code changes while it is settling, and emits one-cycle press, release and optional auto-repeat pulses.
- Sits between the keypad scanner and the key-event consumer (display/command logic), in the scanner clock domain.

Parameters:
- WIDTH, 4, key code width in bits.
- PRESS_CYCLES, 1200, clk cycles key_pressed and the code must be stable before a press is accepted (>=1).
- RELEASE_CYCLES, 1200, clk cycles key_pressed must stay low before a release is accepted (>=1).
- REPEAT_EN, 0, 1 enables auto-repeat pulses while a key is held.
- REPEAT_DELAY, 24000, clk cycles in HELD before the first repeat pulse (>=1).
- REPEAT_PERIOD, 4800, clk cycles between subsequent repeat pulses (>=1).

Ports:
- clk  input  1  scanner clock.
- reset  input  1  synchronous, active-low reset.
- sig_in  input  WIDTH  raw key code from the scanner.
- key_pressed  input  1  raw "a key is down" indication from the scanner.
- sig_out  output  WIDTH  last accepted (debounced) key code.
- press_pulse  output  1  one-cycle strobe when a press is accepted.
- release_pulse  output  1  one-cycle strobe when a release is accepted.
- repeat_pulse  output  1  one-cycle auto-repeat strobe; tied 0 when REPEAT_EN=0.
- held  output  1  high in HELD and DEB_RELEASE.

Behaviour:
- Reset (reset=0 at posedge clk): state=IDLE, counters=0, candidate=all ones, sig_out=all ones, all pulses=0, held=0. Reset overrides everything, including mid-debounce and mid-hold.
- All outputs are registered. Counter widths are $clog2 of the largest count + 1, so counters never wrap.
- FSM states: IDLE, DEB_PRESS, HELD, DEB_RELEASE. Default/illegal state goes to IDLE.
- IDLE:
  - key_pressed=1 -> DEB_PRESS; candidate<=sig_in; cnt<=0.
- DEB_PRESS (checks apply in priority order):
  - (a) key_pressed=0 -> IDLE, no pulse; sig_out unchanged.
  - (b) sig_in!=candidate -> stay; candidate<=sig_in; cnt<=0.
  - (c) otherwise cnt<=cnt+1. On the cycle cnt==PRESS_CYCLES-1 -> HELD; sig_out<=candidate; press_pulse<=1; rcnt<=0.
  - Latency: with stable inputs first sampled at edge t, sig_out and press_pulse are visible after edge t+PRESS_CYCLES.
- HELD:
  - key_pressed=0 -> DEB_RELEASE; cnt<=0.
  - sig_in changes are ignored; sig_out holds.
  - If REPEAT_EN: rcnt<=rcnt+1. repeat_pulse fires when rcnt reaches REPEAT_DELAY-1, then every REPEAT_PERIOD cycles after that; rcnt saturates/reloads so there is no overflow.
- DEB_RELEASE:
  - key_pressed=1 -> HELD (bounce), no pulse; rcnt resumes without reset. No repeat pulses while in DEB_RELEASE.
  - Otherwise cnt<=cnt+1. On the cycle cnt==RELEASE_CYCLES-1 -> IDLE; release_pulse<=1; sig_out holds the last code.
- Pulses:
  - Each pulse is high for exactly one cycle.
  - press_pulse and release_pulse are mutually exclusive.
  - repeat_pulse never coincides with press_pulse.
- Simultaneous events:
  - Count reaching terminal while key_pressed drops (DEB_PRESS): abort wins.
  - Count reaching terminal while key_pressed rises (DEB_RELEASE): return to HELD wins.

Test Plan (PRESS_CYCLES=5, RELEASE_CYCLES=4, REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_PERIOD=3, WIDTH=4):
- Reset mid-hold (state HELD, sig_out=4'h7), reset low 1 cycle -> sig_out=4'hF, held=0, no pulses, state IDLE.
- key_pressed=1, sig_in=4'h3 held 5 cycles -> press_pulse high exactly 1 cycle at edge t+5, sig_out=4'h3, held=1.
- key_pressed=1 for 3 cycles then 0 -> no press_pulse, sig_out stays 4'hF.
- sig_in=4'h3 for 3 cycles then 4'h6 with key_pressed=1 -> counter restarts; press_pulse at 5 cycles after the change, sig_out=4'h6.
- Hold 4'h6 for 20 cycles -> repeat_pulse at HELD cycles 10, 13, 16, 19; sig_out stays 4'h6 even if sig_in toggles to 4'h1.
- Release with one bounce (key_pressed 0 for 2 cycles, 1 for 1 cycle, then 0) -> no release_pulse on the bounce; release_pulse once, 4 cycles after the final drop; sig_out stays 4'h6, held=0.
